// File: rtl/mem_arbiter_if.sv
// Requester-side and mem-side signal bundle for mem_arbiter.
// slave is the arbiter's view; master is the requesters' and memory's view.
interface mem_arbiter_if;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [15:0] addr0;
  logic [15:0] addr1;
  logic [15:0] wdata0;
  logic [15:0] wdata1;
  logic        ready0;
  logic        ready1;
  logic        rvalid0;
  logic        rvalid1;
  logic [15:0] rdata0;
  logic [15:0] rdata1;
  logic        mem_read_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_write_en;
  logic [15:0] mem_write_addr;
  logic [15:0] mem_write_data;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data,
    output ready0, ready1, rvalid0, rvalid1, rdata0, rdata1,
           mem_read_en, mem_addr, mem_write_en, mem_write_addr, mem_write_data
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data,
    input  ready0, ready1, rvalid0, rvalid1, rdata0, rdata1,
           mem_read_en, mem_addr, mem_write_en, mem_write_addr, mem_write_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the data-side read/write ports of mem between
// two requesters; sequences the fixed mem read latency back to the owner.
module mem_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t      state_r;
  state_t      state_nx_s;
  logic        last_r;
  logic        owner_r;
  logic [1:0]  cnt_r;
  logic        rvalid0_r;
  logic        rvalid1_r;
  logic [15:0] rdata0_r;
  logic [15:0] rdata1_r;

  logic        grant0_s;
  logic        grant1_s;
  logic        any_grant_s;
  logic        win_we_s;
  logic        rd_grant_s;
  logic        capture_s;

  // Winner selection and next-state decode; nothing is granted outside IDLE or in reset.
  always_comb begin
    grant0_s    = 1'b0;
    grant1_s    = 1'b0;
    any_grant_s = 1'b0;
    win_we_s    = 1'b0;
    rd_grant_s  = 1'b0;
    capture_s   = 1'b0;
    state_nx_s  = state_r;

    if ((state_r == ST_IDLE) && !rst) begin
      grant0_s = bus.req0 && (!bus.req1 || last_r);
      grant1_s = bus.req1 && (!bus.req0 || !last_r);
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end

    any_grant_s = grant0_s || grant1_s;
    win_we_s    = grant1_s ? bus.we1 : bus.we0;
    rd_grant_s  = any_grant_s && !win_we_s;

    case (state_r)
      ST_IDLE: begin
        if (rd_grant_s) begin
          state_nx_s = ST_RD_WAIT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_r == 2'd0) begin
          capture_s  = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_RD_WAIT;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, round-robin pointer, read-latency counter and returned read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      last_r    <= 1'b1;
      owner_r   <= 1'b0;
      cnt_r     <= 2'd0;
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      rdata0_r  <= 16'h0000;
      rdata1_r  <= 16'h0000;
    end else begin
      state_r   <= state_nx_s;
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      if (any_grant_s) begin
        last_r <= grant1_s;
      end
      if (rd_grant_s) begin
        owner_r <= grant1_s;
        cnt_r   <= CNT_INIT;
      end else if ((state_r == ST_RD_WAIT) && (cnt_r != 2'd0)) begin
        cnt_r <= cnt_r - 2'd1;
      end
      if (capture_s) begin
        if (owner_r) begin
          rdata1_r  <= bus.mem_data;
          rvalid1_r <= 1'b1;
        end else begin
          rdata0_r  <= bus.mem_data;
          rvalid0_r <= 1'b1;
        end
      end
    end
  end

  // Idle mem address/data follow requester 0.
  assign bus.ready0         = grant0_s;
  assign bus.ready1         = grant1_s;
  assign bus.mem_read_en    = rd_grant_s;
  assign bus.mem_write_en   = any_grant_s && win_we_s;
  assign bus.mem_addr       = grant1_s ? bus.addr1  : bus.addr0;
  assign bus.mem_write_addr = grant1_s ? bus.addr1  : bus.addr0;
  assign bus.mem_write_data = grant1_s ? bus.wdata1 : bus.wdata0;
  assign bus.rvalid0        = rvalid0_r;
  assign bus.rvalid1        = rvalid1_r;
  assign bus.rdata0         = rdata0_r;
  assign bus.rdata1         = rdata1_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: two instances (RD_LAT=1 and RD_LAT=2),
// each with a small latency-accurate mem model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic        pre_we_a;
  logic        pre_we_b;
  logic [7:0]  pre_addr;
  logic [15:0] pre_data;

  mem_arbiter_if ia();
  mem_arbiter_if ib();

  mem_arbiter #(.RD_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  mem_arbiter #(.RD_LAT(2)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

  always #5 clk = ~clk;

  // Memory models: data is only valid exactly RD_LAT cycles after mem_read_en.
  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];
  logic        va, vb1, vb2;
  logic [7:0]  pa, pb1, pb2;

  always @(posedge clk) begin
    if (ia.mem_write_en) mem_a[ia.mem_write_addr[7:0]] <= ia.mem_write_data;
    else if (pre_we_a)   mem_a[pre_addr] <= pre_data;
    va <= ia.mem_read_en;
    pa <= ia.mem_addr[7:0];
  end
  assign ia.mem_data = va ? mem_a[pa] : 16'hDEAD;

  always @(posedge clk) begin
    if (ib.mem_write_en) mem_b[ib.mem_write_addr[7:0]] <= ib.mem_write_data;
    else if (pre_we_b)   mem_b[pre_addr] <= pre_data;
    vb1 <= ib.mem_read_en;
    pb1 <= ib.mem_addr[7:0];
    vb2 <= vb1;
    pb2 <= pb1;
  end
  assign ib.mem_data = vb2 ? mem_b[pb2] : 16'hDEAD;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic sel_b, input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_addr = a;
    pre_data = d;
    pre_we_a = !sel_b;
    pre_we_b = sel_b;
    @(negedge clk);
    pre_we_a = 1'b0;
    pre_we_b = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pre_we_a = 1'b0; pre_we_b = 1'b0; pre_addr = 8'h00; pre_data = 16'h0000;
    ia.req0 = 1'b0; ia.req1 = 1'b0; ia.we0 = 1'b0; ia.we1 = 1'b0;
    ia.addr0 = 16'h0000; ia.addr1 = 16'h0000; ia.wdata0 = 16'h0000; ia.wdata1 = 16'h0000;
    ib.req0 = 1'b0; ib.req1 = 1'b0; ib.we0 = 1'b0; ib.we1 = 1'b0;
    ib.addr0 = 16'h0000; ib.addr1 = 16'h0000; ib.wdata0 = 16'h0000; ib.wdata1 = 16'h0000;

    preload(1'b0, 8'h10, 16'hBEEF);
    preload(1'b0, 8'h20, 16'h5A5A);
    preload(1'b1, 8'h30, 16'hA0A0);
    preload(1'b1, 8'h31, 16'hB1B1);

    // Reset state; a request during reset must not be granted
    @(negedge clk); ia.req0 = 1'b1; #1;
    check_eq("rst_ready0", 16'(ia.ready0), 16'h0);
    check_eq("rst_rden", 16'(ia.mem_read_en), 16'h0);
    check_eq("rst_rvalid0", 16'(ia.rvalid0), 16'h0);
    check_eq("rst_rdata0", ia.rdata0, 16'h0000);

    // Single read, RD_LAT=1
    @(negedge clk); rst = 1'b0; ia.req0 = 1'b1; ia.we0 = 1'b0; ia.addr0 = 16'h0010; #1;
    check_eq("t1_ready0", 16'(ia.ready0), 16'h1);
    check_eq("t1_ready1", 16'(ia.ready1), 16'h0);
    check_eq("t1_rden", 16'(ia.mem_read_en), 16'h1);
    check_eq("t1_addr", ia.mem_addr, 16'h0010);
    check_eq("t1_wren", 16'(ia.mem_write_en), 16'h0);
    @(negedge clk); ia.req0 = 1'b0; #1;
    check_eq("t1_c1_ready0", 16'(ia.ready0), 16'h0);
    check_eq("t1_c1_rvalid0", 16'(ia.rvalid0), 16'h0);
    @(negedge clk); #1;
    check_eq("t1_c2_rvalid0", 16'(ia.rvalid0), 16'h1);
    check_eq("t1_c2_rdata0", ia.rdata0, 16'hBEEF);
    check_eq("t1_c2_rvalid1", 16'(ia.rvalid1), 16'h0);
    @(negedge clk); #1;
    check_eq("t1_c3_rvalid0", 16'(ia.rvalid0), 16'h0);
    check_eq("t1_c3_rdata0", ia.rdata0, 16'hBEEF);

    // Continuous reads from both, RD_LAT=2: grants every 3 cycles, alternating
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (k == 0) begin
        ib.req0 = 1'b1; ib.we0 = 1'b0; ib.addr0 = 16'h0030;
        ib.req1 = 1'b1; ib.we1 = 1'b0; ib.addr1 = 16'h0031;
      end
      #1;
      check_eq($sformatf("t3_ready0_k%0d", k), 16'(ib.ready0), 16'((k % 6) == 0));
      check_eq($sformatf("t3_ready1_k%0d", k), 16'(ib.ready1), 16'((k % 6) == 3));
      check_eq($sformatf("t3_rvalid0_k%0d", k), 16'(ib.rvalid0), 16'((k % 6) == 3));
      check_eq($sformatf("t3_rvalid1_k%0d", k), 16'(ib.rvalid1), 16'((k > 0) && ((k % 6) == 0)));
      if ((k % 6) == 3) begin
        check_eq($sformatf("t3_addr_k%0d", k), ib.mem_addr, 16'h0031);
        check_eq($sformatf("t3_rdata0_k%0d", k), ib.rdata0, 16'hA0A0);
      end
      if ((k > 0) && ((k % 6) == 0)) check_eq($sformatf("t3_rdata1_k%0d", k), ib.rdata1, 16'hB1B1);
    end
    @(negedge clk); ib.req0 = 1'b0; ib.req1 = 1'b0;
    repeat (4) @(negedge clk);

    // Simultaneous writes after reset: 0 first, then 1
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    ia.req0 = 1'b1; ia.we0 = 1'b1; ia.addr0 = 16'h0001; ia.wdata0 = 16'h1111;
    ia.req1 = 1'b1; ia.we1 = 1'b1; ia.addr1 = 16'h0002; ia.wdata1 = 16'h2222; #1;
    check_eq("t2_c0_ready0", 16'(ia.ready0), 16'h1);
    check_eq("t2_c0_ready1", 16'(ia.ready1), 16'h0);
    check_eq("t2_c0_wren", 16'(ia.mem_write_en), 16'h1);
    check_eq("t2_c0_rden", 16'(ia.mem_read_en), 16'h0);
    check_eq("t2_c0_waddr", ia.mem_write_addr, 16'h0001);
    check_eq("t2_c0_wdata", ia.mem_write_data, 16'h1111);
    @(negedge clk); ia.req0 = 1'b0; #1;
    check_eq("t2_c1_ready1", 16'(ia.ready1), 16'h1);
    check_eq("t2_c1_waddr", ia.mem_write_addr, 16'h0002);
    check_eq("t2_c1_wdata", ia.mem_write_data, 16'h2222);
    @(negedge clk); ia.req1 = 1'b0; ia.we0 = 1'b0; ia.we1 = 1'b0; #1;
    check_eq("t2_wren_off", 16'(ia.mem_write_en), 16'h0);
    check_eq("t2_mem1", mem_a[1], 16'h1111);
    check_eq("t2_mem2", mem_a[2], 16'h2222);

    // req1 arriving during requester 0's RD_WAIT waits one cycle
    @(negedge clk); ia.req0 = 1'b1; ia.addr0 = 16'h0010; #1;
    check_eq("t4_n_ready0", 16'(ia.ready0), 16'h1);
    @(negedge clk); ia.req0 = 1'b0; ia.req1 = 1'b1; ia.addr1 = 16'h0020; #1;
    check_eq("t4_n1_ready1", 16'(ia.ready1), 16'h0);
    @(negedge clk); #1;
    check_eq("t4_n2_ready1", 16'(ia.ready1), 16'h1);
    check_eq("t4_n2_rvalid0", 16'(ia.rvalid0), 16'h1);
    check_eq("t4_n2_addr", ia.mem_addr, 16'h0020);
    @(negedge clk); ia.req1 = 1'b0; #1;
    check_eq("t4_n3_ready1", 16'(ia.ready1), 16'h0);
    @(negedge clk); #1;
    check_eq("t4_n4_rvalid1", 16'(ia.rvalid1), 16'h1);
    check_eq("t4_n4_rdata1", ia.rdata1, 16'h5A5A);
    check_eq("t4_n4_rdata0", ia.rdata0, 16'hBEEF);

    // Write then read same address
    @(negedge clk); ia.req0 = 1'b1; ia.we0 = 1'b1; ia.addr0 = 16'h0040; ia.wdata0 = 16'hCAFE; #1;
    check_eq("t6_c0_ready0", 16'(ia.ready0), 16'h1);
    check_eq("t6_c0_wren", 16'(ia.mem_write_en), 16'h1);
    @(negedge clk); ia.we0 = 1'b0; #1;
    check_eq("t6_c1_ready0", 16'(ia.ready0), 16'h1);
    check_eq("t6_c1_rden", 16'(ia.mem_read_en), 16'h1);
    @(negedge clk); ia.req0 = 1'b0; #1;
    check_eq("t6_c2_rvalid0", 16'(ia.rvalid0), 16'h0);
    @(negedge clk); #1;
    check_eq("t6_c3_rvalid0", 16'(ia.rvalid0), 16'h1);
    check_eq("t6_c3_rdata0", ia.rdata0, 16'hCAFE);

    // Reset during RD_WAIT drops the read and restores requester 0 priority
    @(negedge clk); ia.req0 = 1'b1; ia.addr0 = 16'h0010; #1;
    check_eq("t5_c0_ready0", 16'(ia.ready0), 16'h1);
    @(negedge clk); rst = 1'b1; #1;
    check_eq("t5_c1_ready0", 16'(ia.ready0), 16'h0);
    check_eq("t5_c1_rden", 16'(ia.mem_read_en), 16'h0);
    @(negedge clk); rst = 1'b0;
    ia.req0 = 1'b1; ia.addr0 = 16'h0020; ia.req1 = 1'b1; ia.addr1 = 16'h0010; #1;
    check_eq("t5_c2_rvalid0", 16'(ia.rvalid0), 16'h0);
    check_eq("t5_c2_rvalid1", 16'(ia.rvalid1), 16'h0);
    check_eq("t5_c2_rdata0", ia.rdata0, 16'h0000);
    check_eq("t5_c2_rdata1", ia.rdata1, 16'h0000);
    check_eq("t5_c2_ready0", 16'(ia.ready0), 16'h1);
    check_eq("t5_c2_ready1", 16'(ia.ready1), 16'h0);
    @(negedge clk); ia.req0 = 1'b0; #1;
    check_eq("t5_c3_ready1", 16'(ia.ready1), 16'h0);
    @(negedge clk); #1;
    check_eq("t5_c4_rvalid0", 16'(ia.rvalid0), 16'h1);
    check_eq("t5_c4_rdata0", ia.rdata0, 16'h5A5A);
    check_eq("t5_c4_ready1", 16'(ia.ready1), 16'h1);
    @(negedge clk); ia.req1 = 1'b0; #1;
    check_eq("t5_c5_rvalid1", 16'(ia.rvalid1), 16'h0);
    @(negedge clk); #1;
    check_eq("t5_c6_rvalid1", 16'(ia.rvalid1), 16'h1);
    check_eq("t5_c6_rdata1", ia.rdata1, 16'hBEEF);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the data-side read and write ports of `mem` (`mem_read_en`/`mem_addr`/`mem_data`, `mem_write_en`/`mem_write_addr`/`mem_write_data`) between requester 0 (CPU load/store stage) and requester 1 (loader/debug port). It sits between both requesters and `mem` in the top-level `main`. It grants at most one access per cycle with round-robin priority and sequences the fixed read latency of `mem`, returning read data to the owning requester. The instruction fetch port (`pc`) is not arbitrated.

## Interface
- `RD_LAT`, default 1: cycles from `mem_read_en` to valid `mem_data` (legal 1–3).
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0` / `req1`  in  1  access request; held until `ready` seen.
- `we0` / `we1`  in  1  1 = write, 0 = read; stable while `req` high.
- `addr0` / `addr1`  in  16  word address.
- `wdata0` / `wdata1`  in  16  write data.
- `ready0` / `ready1`  out  1  combinational grant; the request is accepted in the cycle `req && ready`.
- `rvalid0` / `rvalid1`  out  1  one-cycle pulse; `rdata` is valid.
- `rdata0` / `rdata1`  out  16  registered read data.
- `mem_read_en`  out  1  to `mem`.
- `mem_addr`  out  16  to `mem`.
- `mem_data`  in  16  from `mem`, valid `RD_LAT` cycles after `mem_read_en`.
- `mem_write_en`, `mem_write_addr` (16), `mem_write_data` (16)  out  to `mem`.

## Operation
- States: IDLE and RD_WAIT. Registers: `last` (last granted requester), `owner`, `cnt` (2 bits).
- In IDLE, the winner is chosen from the active requests:
  - A single active request wins.
  - If both are active, the requester ≠ `last` wins.
  - The winner's `ready` goes high; the loser's `ready` stays 0.
  - `last` is updated to the winner on every grant, read or write.
- Write grant: `mem_write_en` = 1, with `mem_write_addr`/`mem_write_data` taken from the winner, in the same cycle. The state stays IDLE.
- Read grant: `mem_read_en` = 1 and `mem_addr` = winner's address in the same cycle. `owner` ← winner, `cnt` ← `RD_LAT`-1, state → RD_WAIT.
- In RD_WAIT:
  - All `ready` = 0; `mem_read_en` = `mem_write_en` = 0.
  - When `cnt` = 0, `mem_data` is captured into `rdata[owner]`, `rvalid[owner]` is set for the next cycle, and state → IDLE. Otherwise `cnt` decrements.
- `rdata` of the non-owner holds its last value.
- When nothing is granted, `mem_*_en` = 0. `mem_addr`/`mem_write_*` are don't-care but are driven from requester 0.
- Reset:
  - State → IDLE, `last` → 1 (requester 0 gets first priority).
  - `rvalid*` → 0, `rdata*` → 0.
  - All `ready` and `mem_*_en` are forced to 0 while `rst` is high.
  - A read in flight is dropped: no `rvalid` is issued after reset.

## Timing
- Read granted in cycle N: `mem_read_en` is high in N, `mem_data` is sampled at the end of N+`RD_LAT`, and `rvalid` is high in cycle N+`RD_LAT`+1.
- The next grant is possible in cycle N+`RD_LAT`+1, the same cycle as `rvalid`.
- Read throughput: one per `RD_LAT`+1 cycles.
- Write granted in N: `mem_write_en` is high in N and the data is written at the end of N. Back-to-back writes can be granted every cycle.
- A read granted in N+1 to an address written in N returns the new data.
- A request arriving during RD_WAIT waits; no request is lost or reordered per requester.
- Worst-case wait with both requesters continuously active: one foreign access.

## Test plan
- Reset, `RD_LAT`=1, `mem[0x0010]`=0xBEEF; `req0` read 0x0010 in cycle 0 → `ready0` and `mem_read_en` high in cycle 0 with `mem_addr`=0x0010; `rvalid0`=1 with `rdata0`=0xBEEF in cycle 2; `rvalid1` stays 0.
- After reset, `req0` and `req1` both write in cycle 0 (addresses 0x0001 and 0x0002, data 0x1111 and 0x2222) and hold → cycle 0 grants 0, cycle 1 grants 1; mem then holds both values.
- Both requesters issue continuous reads with `RD_LAT`=2 → grants alternate 0,1,0,1 every 3 cycles; each `rvalid` goes only to the issuer, with the correct data.
- `req1` is raised during requester 0's RD_WAIT → `ready1` stays 0 until cycle N+`RD_LAT`+1, then is granted.
- `rst` is asserted in the cycle after a read grant → no `rvalid` ever appears; all outputs are 0 on the following edge; next grant goes to requester 0.
- `req0` writes 0xCAFE to 0x0040 in cycle 0, then reads 0x0040 in cycle 1 → `rdata0`=0xCAFE with `rvalid0` in cycle 3 (`RD_LAT`=1).
